// File: rtl/epu_pkg.sv
// epu_pkg: frame geometry and FSM state type shared by the EPU loader files
package epu_pkg;
  localparam int SIGN_WORDS = 16;
  localparam int KEY_WORDS = 8;
  localparam int HASH_WORDS = 8;
  localparam int FRAME_WORDS = 32;
  typedef enum logic [2:0] {LOAD, FIRE, WAIT, RESULT, DRAIN} state_t;
endpackage

// File: rtl/epu_loader_if.sv
// epu_loader_if: ingress stream, EPU start/done and result handshake bundle
interface epu_loader_if;
  import epu_pkg::*;
  logic [31:0] s_data;
  logic s_valid;
  logic s_last;
  logic s_ready;
  logic [SIGN_WORDS*32-1:0] sign;
  logic [KEY_WORDS*32-1:0] key;
  logic [HASH_WORDS*32-1:0] rhash;
  logic epu_valid;
  logic epu_ready;
  logic epu_result;
  logic res_valid;
  logic res_ok;
  logic res_err;
  logic res_ready;
  modport master (
    output s_data, s_valid, s_last, epu_ready, epu_result, res_ready,
    input s_ready, sign, key, rhash, epu_valid, res_valid, res_ok, res_err
  );
  modport slave (
    input s_data, s_valid, s_last, epu_ready, epu_result, res_ready,
    output s_ready, sign, key, rhash, epu_valid, res_valid, res_ok, res_err
  );
endinterface

// File: rtl/epu_loader.sv
// epu_loader: assembles a 32-word frame into sign/key/rhash, starts the EPU once and returns its verdict
module epu_loader
  import epu_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int WORDS = 32
) (
  input logic axiclk,
  input logic resetn,
  epu_loader_if.slave bus
);
  state_t st, nxt;
  logic [4:0] wcnt;
  logic [WORDS*WORD_W-1:0] frame;
  logic rdy, wfirst, ok, err, acc, last_w;
  assign acc = bus.s_valid && rdy;
  assign last_w = wcnt == 5'(WORDS - 1);
  assign bus.s_ready = rdy;
  assign bus.epu_valid = st == FIRE;
  assign bus.res_valid = st == RESULT;
  assign bus.res_ok = ok;
  assign bus.res_err = err;
  assign bus.sign = frame[WORDS*WORD_W-1 -: SIGN_WORDS*32];
  assign bus.key = frame[(KEY_WORDS+HASH_WORDS)*32-1 -: KEY_WORDS*32];
  assign bus.rhash = frame[HASH_WORDS*32-1:0];
  always_comb begin
    nxt = st;
    unique case (st)
      LOAD:    if (acc) nxt = bus.s_last ? (last_w ? FIRE : RESULT) : (last_w ? DRAIN : LOAD);
      FIRE:    nxt = WAIT;
      WAIT:    if (bus.epu_ready && !wfirst) nxt = RESULT;
      RESULT:  if (bus.res_ready) nxt = LOAD;
      DRAIN:   if (acc && bus.s_last) nxt = RESULT;
      default: nxt = LOAD;
    endcase
  end
  // s_ready is registered so it stays low through reset and rises on the first edge after release
  always_ff @(posedge axiclk or negedge resetn)
    if (!resetn) begin
      st <= LOAD;
      wcnt <= '0;
      frame <= '0;
      rdy <= 1'b0;
      wfirst <= 1'b0;
      ok <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= nxt;
      rdy <= nxt == LOAD || nxt == DRAIN;
      wfirst <= st == FIRE;
      if (acc && st == LOAD) begin
        frame[{~wcnt, 5'd0} +: 32] <= bus.s_data;
        wcnt <= (bus.s_last || last_w) ? 5'd0 : wcnt + 5'd1;
      end
      if (nxt == RESULT && st != RESULT) begin
        ok <= st == WAIT && bus.epu_result;
        err <= st != WAIT;
      end
    end
endmodule

// File: tb/tb_epu_loader.sv
// tb_epu_loader: directed+random frame scenarios against a frame-level reference model
module tb_epu_loader;
  logic axiclk = 1'b0;
  logic resetn = 1'b0;
  always #5 axiclk = ~axiclk;
  epu_loader_if bus();
  epu_loader dut (.axiclk(axiclk), .resetn(resetn), .bus(bus));
  int checks = 0;
  int failures = 0;
  int ev_cnt = 0;
  logic [31:0] words [64];
  always @(posedge axiclk) if (bus.epu_valid) ev_cnt++;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge axiclk);
    #1;
  endtask
  task automatic fill();
    for (int i = 0; i < 64; i++) words[i] = $urandom;
  endtask
  task automatic send(input logic [31:0] w, input logic last, input bit bub);
    int t;
    bit a;
    if (bub) begin
      int n;
      n = $urandom_range(0, 2);
      repeat (n) step();
    end
    bus.s_valid = 1'b1;
    bus.s_data = w;
    bus.s_last = last;
    t = 0;
    do begin
      a = bus.s_ready;
      step();
      t++;
    end while (!a && t < 50);
    chk("s_accept", a, 1);
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask
  task automatic run(input int n, input bit bub, input bit res, input int dly, input bit early, input int hold);
    logic [1023:0] f;
    int ev0;
    bit good;
    good = n == 32;
    ev0 = ev_cnt;
    f = '0;
    for (int i = 0; i < 32; i++) f = (f << 32) | 1024'(words[i]);
    for (int i = 0; i < n; i++) send(words[i], i == n - 1, bub);
    if (good) begin
      chk("epu_valid_lat", bus.epu_valid, 1);
      chk("sign", bus.sign, f[1023:512]);
      chk("key", bus.key, f[511:256]);
      chk("rhash", bus.rhash, f[255:0]);
      if (early) begin
        bus.epu_ready = 1'b1;
        bus.epu_result = res;
        step();
        chk("epu_valid_pulse", bus.epu_valid, 0);
        step();
        chk("early_ready_ignored", bus.res_valid, 0);
        step();
      end else begin
        step();
        chk("epu_valid_pulse", bus.epu_valid, 0);
        repeat (dly) step();
        chk("wait_hold", bus.res_valid, 0);
        bus.epu_ready = 1'b1;
        bus.epu_result = res;
        step();
      end
      bus.epu_ready = 1'b0;
      bus.epu_result = 1'b0;
      chk("sign_stable", bus.sign, f[1023:512]);
    end
    chk("res_valid", bus.res_valid, 1);
    chk("res_ok", bus.res_ok, good && res);
    chk("res_err", bus.res_err, !good);
    chk("s_ready_result", bus.s_ready, 0);
    chk("epu_fires", ev_cnt - ev0, good ? 1 : 0);
    repeat (hold) begin
      step();
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_ok", bus.res_ok, good && res);
      chk("bp_res_err", bus.res_err, !good);
      chk("bp_s_ready", bus.s_ready, 0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("back_to_load_ready", bus.s_ready, 1);
    chk("res_consumed", bus.res_valid, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_epu_valid"}, bus.epu_valid, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_ok"}, bus.res_ok, 0);
    chk({tag, "_res_err"}, bus.res_err, 0);
    chk({tag, "_sign"}, bus.sign, 0);
    chk({tag, "_key"}, bus.key, 0);
    chk({tag, "_rhash"}, bus.rhash, 0);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.epu_ready = 1'b0;
    bus.epu_result = 1'b0;
    bus.res_ready = 1'b0;
    #2;
    chk_zero("reset");
    #20;
    resetn = 1'b1;
    #1;
    chk("s_ready_pre_edge", bus.s_ready, 0);
    step();
    chk("s_ready_first_edge", bus.s_ready, 1);
    fill();
    words[0] = 32'h03e302d5;
    words[16] = 32'he8325d4a;
    words[24] = 32'h03788934;
    run(32, 0, 1, 100, 0, 0);
    chk("gold_sign_msw", bus.sign[511:480], 32'h03e302d5);
    words[15] = words[15] ^ 32'h1;
    run(32, 0, 0, 20, 0, 0);
    fill();
    run(11, 0, 1, 0, 0, 0);
    fill();
    run(40, 0, 1, 0, 0, 0);
    fill();
    run(32, 1, 1, 5, 1, 50);
    fill();
    run(32, 1, 0, 3, 0, 0);
    fill();
    for (int i = 0; i < 32; i++) send(words[i], i == 31, 0);
    chk("rw_epu_valid", bus.epu_valid, 1);
    step();
    resetn = 1'b0;
    #1;
    chk_zero("rst_wait");
    step();
    step();
    #3;
    resetn = 1'b1;
    #1;
    chk("rw_s_ready_pre_edge", bus.s_ready, 0);
    step();
    chk("rw_s_ready_first_edge", bus.s_ready, 1);
    bus.epu_ready = 1'b1;
    bus.epu_result = 1'b1;
    step();
    step();
    bus.epu_ready = 1'b0;
    bus.epu_result = 1'b0;
    repeat (5) begin
      step();
      chk("rw_no_result", bus.res_valid, 0);
    end
    fill();
    run(32, 0, 1, 10, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
